seq_match_monitor: RTL and testbench

Downstream consumer of the `seq_detector` Mealy "111" detector output `z`. It counts match pulses over fixed windows of `WINDOW` clock cycles and reports each window's count with a one-cycle valid strobe. It also raises a sticky alarm when a full window reaches `THRESH` matches, and keeps a saturating lifetime total plus the longest run of back-to-back matches. Overlapping input such as 1111 produces consecutive `z` pulses.

---
 rtl/seq_match_monitor_if.sv | 26 ++
 rtl/seq_match_monitor.sv | 156 +++++++++++++++
 tb/tb_seq_match_monitor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_match_monitor_if.sv
// Bus bundle between a match-pulse producer and seq_match_monitor.
// The master drives the detector pulse and the control strobes; the
// slave (the monitor) drives back the window report and lifetime stats.
interface seq_match_monitor_if #(
    parameter int CNT_W = 8
);
    logic             z;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] win_count;
    logic             win_valid;
    logic             win_partial;
    logic             alarm;
    logic [15:0]      total;
    logic [7:0]       max_run;

    modport master (
        output z, en, clr,
        input  win_count, win_valid, win_partial, alarm, total, max_run
    );

    modport slave (
        input  z, en, clr,
        output win_count, win_valid, win_partial, alarm, total, max_run
    );
endinterface

// File: rtl/seq_match_monitor.sv
// Windowed match counter for the "111" detector output. Counts z pulses
// over WINDOW-cycle windows, strobes each window's count, raises a sticky
// alarm on busy full windows, and keeps a saturating lifetime total plus
// the longest run of back-to-back matches.
module seq_match_monitor #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input logic                clk,
    input logic                reset,
    seq_match_monitor_if.slave bus
);
    localparam int IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] acc, acc_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       run, run_n;
    logic [CNT_W-1:0] count_r, count_n;
    logic             valid_r, valid_n;
    logic             partial_r, partial_n;
    logic             alarm_r, alarm_n;
    logic [15:0]      total_r, total_n;
    logic [7:0]       max_r, max_n;
    logic [CNT_W-1:0] acc_sum;

    // Saturating increment of the window accumulator.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a, input logic inc);
        return (inc && (a != {CNT_W{1'b1}})) ? a + 1'b1 : a;
    endfunction

    // Saturating increment of the lifetime total.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic inc);
        return (inc && (a != 16'hFFFF)) ? a + 16'd1 : a;
    endfunction

    // Saturating increment of the run length.
    function automatic logic [7:0] sat8(input logic [7:0] a, input logic inc);
        return (inc && (a != 8'hFF)) ? a + 8'd1 : a;
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-value logic; clr overrides everything.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        idx_n     = idx;
        run_n     = run;
        count_n   = count_r;
        valid_n   = 1'b0;
        partial_n = partial_r;
        alarm_n   = alarm_r;
        total_n   = total_r;
        max_n     = max_r;
        acc_sum   = sat_cnt(acc, bus.z);

        if (bus.clr) begin
            state_n   = IDLE;
            acc_n     = '0;
            idx_n     = '0;
            run_n     = '0;
            count_n   = '0;
            partial_n = 1'b0;
            alarm_n   = 1'b0;
            total_n   = '0;
            max_n     = '0;
        end else begin
            case (state)
                IDLE: begin
                    // z is deliberately ignored on the entry cycle.
                    if (bus.en) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        total_n = sat16(total_r, bus.z);
                        run_n   = bus.z ? sat8(run, 1'b1) : 8'd0;
                        if (run_n > max_r) begin
                            max_n = run_n;
                        end
                        if (idx == LAST_IDX) begin
                            count_n   = acc_sum;
                            valid_n   = 1'b1;
                            partial_n = 1'b0;
                            if (int'(acc_sum) >= THRESH) begin
                                alarm_n = 1'b1;
                            end
                            acc_n = '0;
                            idx_n = '0;
                        end else begin
                            acc_n = acc_sum;
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        // Leaving RUN: flush a partial window if any edge was counted.
                        state_n = IDLE;
                        run_n   = '0;
                        acc_n   = '0;
                        idx_n   = '0;
                        if (idx != '0) begin
                            count_n   = acc;
                            valid_n   = 1'b1;
                            partial_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Counters, report registers and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            idx       <= '0;
            run       <= '0;
            count_r   <= '0;
            valid_r   <= 1'b0;
            partial_r <= 1'b0;
            alarm_r   <= 1'b0;
            total_r   <= '0;
            max_r     <= '0;
        end else begin
            acc       <= acc_n;
            idx       <= idx_n;
            run       <= run_n;
            count_r   <= count_n;
            valid_r   <= valid_n;
            partial_r <= partial_n;
            alarm_r   <= alarm_n;
            total_r   <= total_n;
            max_r     <= max_n;
        end
    end

    assign bus.win_count   = count_r;
    assign bus.win_valid   = valid_r;
    assign bus.win_partial = partial_r;
    assign bus.alarm       = alarm_r;
    assign bus.total       = total_r;
    assign bus.max_run     = max_r;
endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor: two instances (CNT_W=8 and CNT_W=2) share
// one stimulus stream; a window-level model predicts every output each
// cycle, and directed literal checks pin the model at key points.
module tb_seq_match_monitor;
    localparam int WIN = 16;
    localparam int TH  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic z_in = 1'b0;
    logic en_in = 1'b0;
    logic clr_in = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    seq_match_monitor_if #(.CNT_W(8)) bus_a ();
    seq_match_monitor_if #(.CNT_W(2)) bus_b ();

    assign bus_a.z = z_in;
    assign bus_a.en = en_in;
    assign bus_a.clr = clr_in;
    assign bus_b.z = z_in;
    assign bus_b.en = en_in;
    assign bus_b.clr = clr_in;

    seq_match_monitor #(.WINDOW(WIN), .CNT_W(8), .THRESH(TH)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    seq_match_monitor #(.WINDOW(WIN), .CNT_W(2), .THRESH(TH)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Model state: unbounded integers, clipped only when compared.
    int cmax[2] = '{255, 3};
    bit m_active[2];
    int m_len[2], m_pulses[2], m_total[2], m_run[2], m_max[2];
    int e_count[2];
    bit e_valid[2], e_partial[2], e_alarm[2];

    function automatic int clip(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_clear(input int k);
        m_active[k] = 1'b0; m_len[k] = 0; m_pulses[k] = 0; m_total[k] = 0;
        m_run[k] = 0; m_max[k] = 0; e_count[k] = 0; e_valid[k] = 1'b0;
        e_partial[k] = 1'b0; e_alarm[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        e_valid[k] = 1'b0;
        if (clr_in) begin
            model_clear(k);
        end else if (!m_active[k]) begin
            if (en_in) m_active[k] = 1'b1;
        end else if (en_in) begin
            m_len[k]++;
            m_pulses[k] += int'(z_in);
            m_total[k] += int'(z_in);
            m_run[k] = z_in ? m_run[k] + 1 : 0;
            if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
            if (m_len[k] == WIN) begin
                e_count[k] = clip(m_pulses[k], cmax[k]);
                e_valid[k] = 1'b1;
                e_partial[k] = 1'b0;
                if (e_count[k] >= TH) e_alarm[k] = 1'b1;
                m_len[k] = 0;
                m_pulses[k] = 0;
            end
        end else begin
            m_active[k] = 1'b0;
            m_run[k] = 0;
            if (m_len[k] != 0) begin
                e_count[k] = clip(m_pulses[k], cmax[k]);
                e_valid[k] = 1'b1;
                e_partial[k] = 1'b1;
            end
            m_len[k] = 0;
            m_pulses[k] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every edge, cleared by async reset.
    initial begin
        model_clear(0);
        model_clear(1);
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear(0);
                model_clear(1);
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("a.win_count", int'(bus_a.win_count), e_count[0]);
                chk("a.win_valid", int'(bus_a.win_valid), int'(e_valid[0]));
                chk("a.win_partial", int'(bus_a.win_partial), int'(e_partial[0]));
                chk("a.alarm", int'(bus_a.alarm), int'(e_alarm[0]));
                chk("a.total", int'(bus_a.total), clip(m_total[0], 65535));
                chk("a.max_run", int'(bus_a.max_run), clip(m_max[0], 255));
                chk("b.win_count", int'(bus_b.win_count), e_count[1]);
                chk("b.win_valid", int'(bus_b.win_valid), int'(e_valid[1]));
                chk("b.win_partial", int'(bus_b.win_partial), int'(e_partial[1]));
                chk("b.alarm", int'(bus_b.alarm), int'(e_alarm[1]));
                chk("b.total", int'(bus_b.total), clip(m_total[1], 65535));
                chk("b.max_run", int'(bus_b.max_run), clip(m_max[1], 255));
            end
        end
    end

    // Drive one cycle of inputs (called at a falling edge), wait for the next falling edge.
    task automatic step(input logic zi, input logic ei, input logic ci);
        z_in = zi;
        en_in = ei;
        clr_in = ci;
        @(negedge clk);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, ".count"}, int'(bus_a.win_count), 0);
        chk({tag, ".valid"}, int'(bus_a.win_valid), 0);
        chk({tag, ".partial"}, int'(bus_a.win_partial), 0);
        chk({tag, ".alarm"}, int'(bus_a.alarm), 0);
        chk({tag, ".total"}, int'(bus_a.total), 0);
        chk({tag, ".max_run"}, int'(bus_a.max_run), 0);
    endtask

    logic [15:0] zpat;

    initial begin
        repeat (3) @(negedge clk);
        chk_zero_a("rst");
        reset = 1'b0;

        // Single window: pulses at cycles 2,3,4.
        step(0, 1, 0);
        for (int i = 0; i < WIN; i++) step((i >= 2 && i <= 4), 1, 0);
        chk("t1.valid", int'(bus_a.win_valid), 1);
        chk("t1.count", int'(bus_a.win_count), 3);
        chk("t1.partial", int'(bus_a.win_partial), 0);
        chk("t1.alarm", int'(bus_a.alarm), 1);
        chk("t1.total", int'(bus_a.total), 3);
        chk("t1.max_run", int'(bus_a.max_run), 3);

        // Below threshold, then an empty window exactly WIN cycles later.
        step(0, 0, 1);
        chk_zero_a("t2.clr");
        step(0, 1, 0);
        for (int i = 0; i < WIN; i++) step((i == 5 || i == 9), 1, 0);
        chk("t2.valid", int'(bus_a.win_valid), 1);
        chk("t2.count", int'(bus_a.win_count), 2);
        chk("t2.alarm", int'(bus_a.alarm), 0);
        for (int i = 0; i < WIN - 1; i++) begin
            step(0, 1, 0);
            chk("t2.gap_valid", int'(bus_a.win_valid), 0);
        end
        step(0, 1, 0);
        chk("t2.valid2", int'(bus_a.win_valid), 1);
        chk("t2.count2", int'(bus_a.win_count), 0);

        // Partial window: 5 counted cycles, 4 pulses, z=1 on the en=0 cycle.
        zpat = 16'b11011;
        for (int i = 0; i < 5; i++) step(zpat[i], 1, 0);
        step(1, 0, 0);
        chk("t3.valid", int'(bus_a.win_valid), 1);
        chk("t3.partial", int'(bus_a.win_partial), 1);
        chk("t3.count", int'(bus_a.win_count), 4);
        chk("t3.alarm", int'(bus_a.alarm), 0);
        chk("t3.total", int'(bus_a.total), 6);
        step(0, 0, 0);
        chk("t3.valid_once", int'(bus_a.win_valid), 0);
        chk("t3.total_hold", int'(bus_a.total), 6);

        // Window count saturation on the narrow instance.
        step(0, 1, 0);
        for (int i = 0; i < WIN; i++) step((i < 6), 1, 0);
        chk("t4.a_count", int'(bus_a.win_count), 6);
        chk("t4.b_count", int'(bus_b.win_count), 3);
        chk("t4.b_alarm", int'(bus_b.alarm), 1);
        step(0, 0, 0);
        chk("t4.no_report", int'(bus_a.win_valid), 0);

        // Overlap run from detector input 0,1,1,1,1,1,0.
        step(0, 0, 1);
        step(0, 1, 0);
        zpat = 16'b0000_0010_0011_1000;
        for (int i = 0; i < 6; i++) step(zpat[i], 1, 0);
        chk("t5.max_run", int'(bus_a.max_run), 3);
        for (int i = 6; i < WIN; i++) step(zpat[i], 1, 0);
        chk("t5.max_run_hold", int'(bus_a.max_run), 3);
        chk("t5.count", int'(bus_a.win_count), 4);
        chk("t5.alarm", int'(bus_a.alarm), 1);

        // clr at cycle 7 with alarm set.
        for (int i = 0; i < 7; i++) step(1, 1, 0);
        step(1, 1, 1);
        chk_zero_a("t6.clr");
        step(1, 1, 0);
        chk("t6.idle_total", int'(bus_a.total), 0);

        // Async reset between edges.
        step(1, 1, 0);
        step(1, 1, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero_a("t7.rst");
        chk("t7.b_total", int'(bus_b.total), 0);
        #1 reset = 1'b0;
        @(negedge clk);
        step(0, 0, 0);
        chk("t7.no_partial", int'(bus_a.win_valid), 0);

        // Lifetime total and run saturation.
        step(0, 1, 0);
        for (int i = 0; i < 65540; i++) step(1, 1, 0);
        chk("t8.total", int'(bus_a.total), 65535);
        chk("t8.max_run", int'(bus_a.max_run), 255);
        chk("t8.b_total", int'(bus_b.total), 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
